avmm_rdwr_mem_responder: RTL and testbench

Responder (slave) end of the split read/write Avalon-MM host-memory channel that AFUs drive as masters. Backs the bus with a small on-chip dual-port RAM so DMA-issuing AFU logic can run against a local, deterministic memory model in simulation and in loopback bring-up builds. It sits where the PIM host-memory port would normally connect, presenting the same bursting semantics.

---
 rtl/avmm_rdwr_mem_responder_pkg.sv | 18 +
 rtl/avmm_rdwr_mem_responder_ram.sv | 46 ++++
 rtl/avmm_rdwr_mem_responder.sv | 213 +++++++++++++++++++++
 tb/tb_avmm_rdwr_mem_responder.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avmm_rdwr_mem_responder_pkg.sv
// Shared types and constants for the Avalon-MM read/write memory responder.
package avmm_rdwr_mem_responder_pkg;

  // Read command FSM: idle (accepting) or streaming RAM reads for a burst
  typedef enum logic {
    R_IDLE  = 1'b0,
    R_BURST = 1'b1
  } rd_state_e;

  // Write FSM: idle (next beat starts a burst) or mid-burst
  typedef enum logic {
    W_IDLE  = 1'b0,
    W_BURST = 1'b1
  } wr_state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/avmm_rdwr_mem_responder_ram.sv
// Simple dual-port RAM: byte-enabled write port, registered read port
// (one cycle latency). A read and a write to the same line in the same
// cycle return the old contents. The array itself is never reset.
module avmm_rdwr_mem_responder_ram #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 512
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Byte-masked write; untouched bytes keep their value
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
        if (wbe[b]) begin
          mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // Registered read; NBA ordering gives old-data read-during-write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/avmm_rdwr_mem_responder.sv
// Avalon-MM split read/write responder backed by an on-chip dual-port RAM.
// Optional feature macro: AVMM_RESPONDER_WR_RESP_EN enables the per-burst
// write response pulse; when undefined wr_writeresponsevalid is tied low.
module avmm_rdwr_mem_responder
  import avmm_rdwr_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 8,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned BURST_CNT_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  // Read channel
  input  logic [ADDR_WIDTH-1:0]      rd_address,
  input  logic                       rd_read,
  input  logic [BURST_CNT_WIDTH-1:0] rd_burstcount,
  input  logic [DATA_WIDTH/8-1:0]    rd_byteenable,
  output logic                       rd_waitrequest,
  output logic [DATA_WIDTH-1:0]      rd_readdata,
  output logic                       rd_readdatavalid,
  output logic [1:0]                 rd_response,
  // Write channel
  input  logic [ADDR_WIDTH-1:0]      wr_address,
  input  logic                       wr_write,
  input  logic [BURST_CNT_WIDTH-1:0] wr_burstcount,
  input  logic [DATA_WIDTH-1:0]      wr_writedata,
  input  logic [DATA_WIDTH/8-1:0]    wr_byteenable,
  output logic                       wr_waitrequest,
  output logic                       wr_writeresponsevalid,
  output logic [1:0]                 wr_response
);

  localparam logic [BURST_CNT_WIDTH-1:0] ONE = BURST_CNT_WIDTH'(1);

  // Reads always return the full line
  logic unused_rd_byteenable;
  assign unused_rd_byteenable = ^rd_byteenable;

  // ---------------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------------
  rd_state_e                  rd_state_q;
  logic [ADDR_WIDTH-1:0]      rd_addr_q;   // next line to issue
  logic [BURST_CNT_WIDTH-1:0] rd_left_q;   // beats still to issue
  logic                       rd_waitrequest_q;
  logic [BURST_CNT_WIDTH-1:0] rd_count;
  logic                       rd_accept;
  logic                       ram_re;
  logic [ADDR_WIDTH-1:0]      ram_raddr;
  logic [DATA_WIDTH-1:0]      ram_rdata;
  logic                       rd_pipe_q;
  logic                       rd_valid_q;
  logic [DATA_WIDTH-1:0]      rd_data_q;

  assign rd_count  = (rd_burstcount == '0) ? ONE : rd_burstcount;
  assign rd_accept = (rd_state_q == R_IDLE) && rd_read && !rd_waitrequest_q;

  // Beat 0 is issued in the accept cycle so the burst occupies exactly N cycles
  always_comb begin
    ram_re    = 1'b0;
    ram_raddr = rd_address;
    if (rd_state_q == R_BURST) begin
      ram_re    = 1'b1;
      ram_raddr = rd_addr_q;
    end else if (rd_accept) begin
      ram_re = 1'b1;
    end
  end

  // Read command FSM with registered waitrequest
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state_q       <= R_IDLE;
      rd_addr_q        <= '0;
      rd_left_q        <= '0;
      rd_waitrequest_q <= 1'b1;
    end else begin
      unique case (rd_state_q)
        R_IDLE: begin
          rd_waitrequest_q <= 1'b0;
          if (rd_accept) begin
            rd_addr_q <= rd_address + ADDR_WIDTH'(1);
            rd_left_q <= rd_count - ONE;
            if (rd_count > ONE) begin
              rd_state_q       <= R_BURST;
              rd_waitrequest_q <= 1'b1;
            end
          end
        end
        R_BURST: begin
          rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
          rd_left_q <= rd_left_q - ONE;
          if (rd_left_q == ONE) begin
            rd_state_q       <= R_IDLE;
            rd_waitrequest_q <= 1'b0;
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  // Output stage: RAM latency plus one register gives accept+2 beat timing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pipe_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_pipe_q  <= ram_re;
      rd_valid_q <= rd_pipe_q;
      if (rd_pipe_q) begin
        rd_data_q <= ram_rdata;
      end
    end
  end

  assign rd_waitrequest   = rd_waitrequest_q;
  assign rd_readdata      = rd_data_q;
  assign rd_readdatavalid = rd_valid_q;
  assign rd_response      = RESP_OKAY;

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  wr_state_e                  wr_state_q;
  logic [ADDR_WIDTH-1:0]      wr_addr_q;   // line for the next burst beat
  logic [BURST_CNT_WIDTH-1:0] wr_left_q;   // beats still expected
  logic                       wr_waitrequest_q;
  logic [BURST_CNT_WIDTH-1:0] wr_count;
  logic                       wr_accept;
  logic [ADDR_WIDTH-1:0]      ram_waddr;

  assign wr_count  = (wr_burstcount == '0) ? ONE : wr_burstcount;
  assign wr_accept = wr_write && !wr_waitrequest_q;
  assign ram_waddr = (wr_state_q == W_BURST) ? wr_addr_q : wr_address;

  // Write burst FSM; address and count only sampled on the first beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state_q       <= W_IDLE;
      wr_addr_q        <= '0;
      wr_left_q        <= '0;
      wr_waitrequest_q <= 1'b1;
    end else begin
      wr_waitrequest_q <= 1'b0;
      unique case (wr_state_q)
        W_IDLE: begin
          if (wr_accept) begin
            wr_addr_q <= wr_address + ADDR_WIDTH'(1);
            wr_left_q <= wr_count - ONE;
            if (wr_count > ONE) begin
              wr_state_q <= W_BURST;
            end
          end
        end
        W_BURST: begin
          if (wr_accept) begin
            wr_addr_q <= wr_addr_q + ADDR_WIDTH'(1);
            wr_left_q <= wr_left_q - ONE;
            if (wr_left_q == ONE) begin
              wr_state_q <= W_IDLE;
            end
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  assign wr_waitrequest = wr_waitrequest_q;
  assign wr_response    = RESP_OKAY;

`ifdef AVMM_RESPONDER_WR_RESP_EN
  logic wr_last;
  logic wr_resp_valid_q;

  assign wr_last = wr_accept &&
                   ((wr_state_q == W_IDLE) ? (wr_count == ONE) : (wr_left_q == ONE));

  // One pulse the cycle after the final beat of a burst is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_resp_valid_q <= 1'b0;
    end else begin
      wr_resp_valid_q <= wr_last;
    end
  end

  assign wr_writeresponsevalid = wr_resp_valid_q;
`else
  assign wr_writeresponsevalid = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Backing store
  // ---------------------------------------------------------------------------
  avmm_rdwr_mem_responder_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_accept),
    .waddr (ram_waddr),
    .wdata (wr_writedata),
    .wbe   (wr_byteenable),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_avmm_rdwr_mem_responder.sv
// Scoreboard bench for avmm_rdwr_mem_responder: stimulus tasks push expected
// read beats / write responses, negedge monitors pop and compare.
module tb_avmm_rdwr_mem_responder;

  localparam int AW  = 8;
  localparam int DW  = 512;
  localparam int BW  = 3;
  localparam int BEW = DW / 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [AW-1:0]  rd_address = '0;
  logic           rd_read = 1'b0;
  logic [BW-1:0]  rd_burstcount = '0;
  logic [BEW-1:0] rd_byteenable = '0;
  logic           rd_waitrequest;
  logic [DW-1:0]  rd_readdata;
  logic           rd_readdatavalid;
  logic [1:0]     rd_response;
  logic [AW-1:0]  wr_address = '0;
  logic           wr_write = 1'b0;
  logic [BW-1:0]  wr_burstcount = '0;
  logic [DW-1:0]  wr_writedata = '0;
  logic [BEW-1:0] wr_byteenable = '0;
  logic           wr_waitrequest;
  logic           wr_writeresponsevalid;
  logic [1:0]     wr_response;

  avmm_rdwr_mem_responder dut (
    .clk                   (clk),
    .reset                 (reset),
    .rd_address            (rd_address),
    .rd_read               (rd_read),
    .rd_burstcount         (rd_burstcount),
    .rd_byteenable         (rd_byteenable),
    .rd_waitrequest        (rd_waitrequest),
    .rd_readdata           (rd_readdata),
    .rd_readdatavalid      (rd_readdatavalid),
    .rd_response           (rd_response),
    .wr_address            (wr_address),
    .wr_write              (wr_write),
    .wr_burstcount         (wr_burstcount),
    .wr_writedata          (wr_writedata),
    .wr_byteenable         (wr_byteenable),
    .wr_waitrequest        (wr_waitrequest),
    .wr_writeresponsevalid (wr_writeresponsevalid),
    .wr_response           (wr_response)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference memory: a plain array of lines
  logic [DW-1:0]  mem_m [256];
  logic [DW-1:0]  wbuf  [8];
  logic [BEW-1:0] bebuf [8];

  // Scoreboard queues
  logic [DW-1:0] exp_rd_data [$];
  int            exp_rd_cyc  [$];
  int            exp_wr_cyc  [$];

  logic [DW-1:0] mon_d;
  int            mon_c;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Read beat monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (exp_rd_cyc.size() != 0 && exp_rd_cyc[0] <= cyc) begin
        mon_d = exp_rd_data.pop_front();
        mon_c = exp_rd_cyc.pop_front();
        n_tests++;
        if (rd_readdatavalid !== 1'b1 || rd_readdata !== mon_d || rd_response !== 2'b00) begin
          n_fail++;
          $display("FAIL rd_beat cyc %0d due %0d: valid=%b resp=%b data=%h expected valid=1 resp=00 data=%h",
                   cyc, mon_c, rd_readdatavalid, rd_response, rd_readdata, mon_d);
        end
      end else if (rd_readdatavalid !== 1'b0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_unexpected: valid=%b at cyc %0d expected 0", rd_readdatavalid, cyc);
      end
    end
  end

  // Write response monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (exp_wr_cyc.size() != 0 && exp_wr_cyc[0] <= cyc) begin
        mon_c = exp_wr_cyc.pop_front();
        n_tests++;
        if (wr_writeresponsevalid !== 1'b1 || wr_response !== 2'b00) begin
          n_fail++;
          $display("FAIL wr_resp cyc %0d due %0d: valid=%b resp=%b expected valid=1 resp=00",
                   cyc, mon_c, wr_writeresponsevalid, wr_response);
        end
      end else if (wr_writeresponsevalid !== 1'b0) begin
        n_tests++;
        n_fail++;
        $display("FAIL wr_resp_unexpected: valid=%b at cyc %0d expected 0",
                 wr_writeresponsevalid, cyc);
      end
    end
  end

  task automatic fill_rand(input bit full_be);
    for (int i = 0; i < 8; i++) begin
      for (int w = 0; w < DW / 32; w++) wbuf[i][w*32 +: 32] = $urandom;
      bebuf[i] = full_be ? {BEW{1'b1}} : {$urandom, $urandom};
    end
  endtask

  // Issue a read command; expected beats come from the model at accept time
  task automatic rd_cmd(input logic [AW-1:0] a, input int n);
    int  neff;
    bit  ok;
    int  t;
    neff = (n == 0) ? 1 : n;
    ok   = 1'b0;
    t    = 0;
    rd_address    = a;
    rd_burstcount = BW'(n);
    rd_byteenable = {$urandom, $urandom};
    rd_read       = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = !rd_waitrequest;
      t  = cyc;
      @(posedge clk);
      #1;
    end
    rd_read    = 1'b0;
    rd_address = AW'($urandom);
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL rd_accept_timeout: waitrequest=%b expected 0 within 20 cycles", rd_waitrequest);
    end else begin
      for (int i = 0; i < neff; i++) begin
        exp_rd_data.push_back(mem_m[AW'(a + i)]);
        exp_rd_cyc.push_back(t + 2 + i);
      end
    end
  endtask

  // Write a burst from wbuf/bebuf; model updated as each beat is accepted
  task automatic wr_burst(input logic [AW-1:0] a, input int n, input bit gaps);
    int neff;
    bit ok;
    int t;
    neff = (n == 0) ? 1 : n;
    t    = 0;
    for (int i = 0; i < neff; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        wr_write = 1'b0;
        @(posedge clk);
        #1;
      end
      if (i == 0) begin
        wr_address    = a;
        wr_burstcount = BW'(n);
      end else begin
        // Only the first beat's address/count matter
        wr_address    = AW'($urandom);
        wr_burstcount = BW'($urandom);
      end
      wr_writedata  = wbuf[i];
      wr_byteenable = bebuf[i];
      wr_write      = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
        @(negedge clk);
        ok = !wr_waitrequest;
        t  = cyc;
        @(posedge clk);
        #1;
      end
      if (!ok) begin
        n_tests++;
        n_fail++;
        $display("FAIL wr_accept_timeout: waitrequest=%b expected 0 within 20 cycles", wr_waitrequest);
      end else begin
        for (int b = 0; b < BEW; b++) begin
          if (bebuf[i][b]) mem_m[AW'(a + i)][b*8 +: 8] = wbuf[i][b*8 +: 8];
        end
      end
    end
    wr_write = 1'b0;
`ifdef AVMM_RESPONDER_WR_RESP_EN
    exp_wr_cyc.push_back(t + 1);
`endif
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && (exp_rd_cyc.size() != 0 || exp_wr_cyc.size() != 0); k++) begin
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    if (exp_rd_cyc.size() != 0 || exp_wr_cyc.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d read beats and %0d write responses outstanding, expected 0",
               exp_rd_cyc.size(), exp_wr_cyc.size());
      exp_rd_cyc.delete();
      exp_rd_data.delete();
      exp_wr_cyc.delete();
    end
  endtask

  initial begin
    logic [AW-1:0] a;
    int            n;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_bit("reset_rd_waitrequest", rd_waitrequest, 1'b1);
    check_bit("reset_wr_waitrequest", wr_waitrequest, 1'b1);
    check_bit("reset_rd_readdatavalid", rd_readdatavalid, 1'b0);
    check_bit("reset_wr_writeresponsevalid", wr_writeresponsevalid, 1'b0);
    check_vec("reset_rd_readdata", rd_readdata, '0);
    check_bit("reset_rd_response_nonzero", |rd_response, 1'b0);
    check_bit("reset_wr_response_nonzero", |wr_response, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_bit("post_reset_rd_waitrequest", rd_waitrequest, 1'b0);
    check_bit("post_reset_wr_waitrequest", wr_waitrequest, 1'b0);
    @(posedge clk);
    #1;

    // Give every line a known value
    for (int blk = 0; blk < 64; blk++) begin
      fill_rand(1'b1);
      wr_burst(AW'(blk * 4), 4, 1'b0);
    end
    drain();

    // Single write then read
    wbuf[0]  = {BEW{8'hA5}};
    bebuf[0] = {BEW{1'b1}};
    wr_burst(8'h10, 1, 1'b0);
    rd_cmd(8'h10, 1);
    drain();

    // Burst wrapping past the top of memory
    for (int i = 0; i < 4; i++) begin
      wbuf[i]  = DW'(i + 1);
      bebuf[i] = {BEW{1'b1}};
    end
    wr_burst(8'hFE, 4, 1'b0);
    rd_cmd(8'hFE, 4);
    drain();

    // Byte masking
    wbuf[0]  = {DW{1'b1}};
    bebuf[0] = {BEW{1'b1}};
    wr_burst(8'h05, 1, 1'b0);
    wbuf[0]  = '0;
    bebuf[0] = BEW'(1);
    wr_burst(8'h05, 1, 1'b0);
    rd_cmd(8'h05, 1);
    drain();

    // Burstcount 0 acts as a single beat
    rd_cmd(8'h20, 0);
    drain();

    // Concurrent read and write channels
    fill_rand(1'b1);
    fork
      begin
        rd_cmd(8'h00, 4);
        for (int k = 1; k <= 3; k++) begin
          @(negedge clk);
          check_bit($sformatf("conc_rd_waitrequest_T+%0d", k), rd_waitrequest, 1'b1);
        end
        @(negedge clk);
        check_bit("conc_rd_waitrequest_T+4", rd_waitrequest, 1'b0);
      end
      wr_burst(8'h08, 4, 1'b0);
    join
    @(posedge clk);
    #1;
    rd_cmd(8'h08, 4);
    drain();

    // Reset in the middle of a read burst
    fill_rand(1'b1);
    wr_burst(8'h30, 4, 1'b0);
    drain();
    rd_cmd(8'h30, 4);
    for (int k = 0; k < 4; k++) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_bit("midreset_rd_readdatavalid", rd_readdatavalid, 1'b0);
    check_bit("midreset_rd_waitrequest", rd_waitrequest, 1'b1);
    check_bit("midreset_wr_waitrequest", wr_waitrequest, 1'b1);
    check_vec("midreset_rd_readdata", rd_readdata, '0);
    exp_rd_cyc.delete();
    exp_rd_data.delete();
    exp_wr_cyc.delete();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_bit("rerelease_rd_waitrequest", rd_waitrequest, 1'b0);
    check_bit("rerelease_wr_waitrequest", wr_waitrequest, 1'b0);
    @(posedge clk);
    #1;
    rd_cmd(8'h31, 1);
    drain();

    // Randomized traffic, near-wrap addresses favoured
    for (int it = 0; it < 60; it++) begin
      a = AW'($urandom);
      if ($urandom_range(0, 3) == 0) a = AW'(8'hFC + $urandom_range(0, 3));
      n = $urandom_range(0, 4);
      if ($urandom_range(0, 1) == 1) begin
        fill_rand($urandom_range(0, 1) == 1);
        wr_burst(a, n, 1'b1);
      end else begin
        rd_cmd(a, n);
        repeat ((n == 0) ? 1 : n) @(posedge clk);
        #1;
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
